ctrl_de_pipe: RTL

Next-generation RV32I/M decode controller with built-in ID/EX control register. Decodes opcode/funct fields in D and drives ImmSrcD combinationally. Registers all other control into E with flush and hold. Adds optional M-extension decode and a multi-cycle MUL/DIV occupancy FSM that raises a stall request to the hazard unit.

---
 rtl/ctrl_pkg.sv | 84 ++++++++
 rtl/ctrl_de_pipe_main_decode.sv | 85 ++++++++
 rtl/ctrl_de_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the D/E decode controller: opcodes, ALU codes,
// immediate/result selects and the control bundle carried from D into E.
package ctrl_pkg;

    localparam logic [6:0] OP_NONE   = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_AND   = 5'b00010;
    localparam logic [4:0] ALU_OR    = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_SLT   = 5'b00101;
    localparam logic [4:0] ALU_SLTU  = 5'b00110;
    localparam logic [4:0] ALU_AUIPC = 5'b01000;
    localparam logic [4:0] ALU_LUI   = 5'b01001;
    localparam logic [4:0] ALU_SLL   = 5'b01010;
    localparam logic [4:0] ALU_SRA   = 5'b01011;
    localparam logic [4:0] ALU_SRL   = 5'b01100;
    localparam logic [1:0] ALU_MDU_PFX = 2'b10;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        result_src_e result_src;
        logic [4:0]  alu_ctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // alt is funct7[5]; it only turns add into sub for register-register ops.
    function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3,
                                                   input logic       alt,
                                                   input logic       is_reg);
        logic [4:0] code;
        case (f3)
            3'b000:  code = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ctrl_de_pipe_main_decode.sv
// Combinational main decoder: opcode/funct fields to control bundle,
// immediate select and an illegal-encoding flag.
module main_decode
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output ctrl_t      ctrl_o,
    output imm_src_e   imm_src_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = CTRL_BUBBLE;
        imm_src_o = IMM_I;
        illegal_o = 1'b0;
        case (op_i)
            OP_LOAD: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                imm_src_o        = IMM_S;
            end
            OP_RTYPE: begin
                if (funct7_i == F7_MULDIV) begin
                    if (ENABLE_M) begin
                        ctrl_o.reg_write = 1'b1;
                        ctrl_o.alu_ctrl  = {ALU_MDU_PFX, funct3_i};
                    end else begin
                        illegal_o = 1'b1;
                    end
                end else if (funct7_i == F7_BASE || funct7_i == F7_ALT) begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_ctrl  = alu_from_funct3(funct3_i, funct7_i[5], 1'b1);
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_IALU: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_ctrl  = alu_from_funct3(funct3_i, funct7_i[5], 1'b0);
            end
            OP_BRANCH: begin
                ctrl_o.branch   = 1'b1;
                ctrl_o.alu_ctrl = ALU_SUB;
                imm_src_o       = IMM_B;
            end
            OP_JAL: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.jump       = 1'b1;
                ctrl_o.result_src = RES_PC4;
                imm_src_o         = IMM_J;
            end
            OP_JALR: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.jump       = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_PC4;
            end
            OP_LUI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_ctrl  = ALU_LUI;
                imm_src_o        = IMM_U;
            end
            OP_AUIPC: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_ctrl  = ALU_AUIPC;
                imm_src_o        = IMM_U;
            end
            OP_NONE: ;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_de_pipe.sv
// RV32I/M decode controller with ID/EX control register and a MUL/DIV
// occupancy FSM that holds E (and asks the hazard unit to stall) for LAT cycles.
module ctrl_de_pipe
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M    = 1'b1,
    parameter int MUL_LATENCY = 1,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       InstrValidD,
    input  logic [6:0] OP,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       FlushE,
    output logic [2:0] ImmSrcD,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       ALUSrcE,
    output logic       BranchE,
    output logic       JumpE,
    output logic [1:0] ResultSrcE,
    output logic [4:0] ALUControlE,
    output logic       MulDivStartE,
    output logic       StallReqE,
    output logic       IllegalE
);

    localparam logic [CNT_W-1:0] MUL_LAT   = CNT_W'(MUL_LATENCY);
    localparam logic [CNT_W-1:0] DIV_LAT   = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] LAT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] LAT_THREE = CNT_W'(3);

    ctrl_t      dec_ctrl;
    imm_src_e   dec_imm;
    logic       dec_illegal;
    ctrl_t      d_ctrl;
    logic       d_illegal;

    ctrl_t      ctrl_q;
    logic       illegal_q;
    mdu_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_e;
    logic       mul_div_e;

    main_decode #(.ENABLE_M(ENABLE_M)) u_main_decode (
        .op_i      (OP),
        .funct3_i  (funct3),
        .funct7_i  (funct7),
        .ctrl_o    (dec_ctrl),
        .imm_src_o (dec_imm),
        .illegal_o (dec_illegal)
    );

    assign ImmSrcD   = dec_imm;
    assign d_ctrl    = (InstrValidD && !dec_illegal) ? dec_ctrl : CTRL_BUBBLE;
    assign d_illegal = InstrValidD && dec_illegal;

    assign mul_div_e = ctrl_q.alu_ctrl[4];
    assign lat_e     = ctrl_q.alu_ctrl[2] ? DIV_LAT : MUL_LAT;

    // BUSY counts down to zero; DONE is the last (non-stalling) cycle of the op.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        StallReqE    = 1'b0;
        MulDivStartE = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mul_div_e) begin
                    MulDivStartE = 1'b1;
                    if (lat_e == LAT_TWO) begin
                        StallReqE = 1'b1;
                        state_d   = ST_DONE;
                    end else if (lat_e > LAT_TWO) begin
                        StallReqE = 1'b1;
                        state_d   = ST_BUSY;
                        cnt_d     = lat_e - LAT_THREE;
                    end
                end
            end
            ST_BUSY: begin
                StallReqE = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= CTRL_BUBBLE;
            illegal_q <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
        end else if (FlushE) begin
            ctrl_q    <= CTRL_BUBBLE;
            illegal_q <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!StallReqE) begin
                ctrl_q    <= d_ctrl;
                illegal_q <= d_illegal;
            end
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign BranchE     = ctrl_q.branch;
    assign JumpE       = ctrl_q.jump;
    assign ResultSrcE  = ctrl_q.result_src;
    assign ALUControlE = ctrl_q.alu_ctrl;
    assign IllegalE    = illegal_q;

endmodule
